// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage and its consumers.
//   DATA_WIDTH          - datapath / PC width in bits
//   INST_MEM_ADDR_WIDTH - word-address width of instruction_memory
//   NOP_INSTR           - bubble word (addi x0,x0,0) used on flush/redirect/reset
//   RESET_PC_DEFAULT    - default PC after reset
//   if_id_t             - IF/ID pipeline register contents, reused by decode
package fetch_unit_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int INST_MEM_ADDR_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic                  valid;
    } if_id_t;

    // True when a byte address is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [DATA_WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Forces a byte address down to its containing word.
    function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// program_counter: PC register, next-PC selection, target alignment and the
// misalignment flag.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   stall_i          - hold PC (ignored when redirect_i is set)
//   redirect_i       - load the (aligned) redirect target
//   redirect_pc_i    - redirect target byte address
//   pc_o             - current PC (register output)
//   pc_plus4_o       - pc_o + 4, wrapping at 2^32
//   misalign_o       - registered one-cycle pulse after a misaligned redirect
module program_counter
    import fetch_unit_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  misalign_o
);

    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  misalign_d;
    logic                  misalign_q;
    logic [DATA_WIDTH-1:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-PC selection: redirect beats stall; flush does not affect the PC.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redirect_i) begin
            pc_d       = align_word(redirect_pc_i);
            misalign_d = is_misaligned(redirect_pc_i);
        end else if (stall_i) begin
            pc_d       = pc_q;
        end else begin
            pc_d       = pc_plus4_s;
        end
    end

    // PC and misalign flag registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_s;
    assign misalign_o = misalign_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage controller. Generates the instruction memory word
// address from the PC and captures the combinational read data, PC and PC+4
// into the IF/ID register. Handles stall, flush and EX redirects.
//   clk_i, rst_i       - clock, synchronous active-high reset
//   stall_i            - hold PC and IF/ID
//   flush_i            - bubble into IF/ID (PC still advances unless stalled)
//   redirect_i         - taken branch/jump: load target, bubble IF/ID
//   redirect_pc_i      - redirect target byte address
//   imem_addr_o        - word address to instruction_memory
//   imem_data_i        - combinational read data from instruction_memory
//   if_pc_o            - current PC
//   id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o - IF/ID register contents
//   misalign_o         - one-cycle pulse after a misaligned redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic                           redirect_i,
    input  logic [DATA_WIDTH-1:0]          redirect_pc_i,
    output logic [INST_MEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0]          imem_data_i,
    output logic [DATA_WIDTH-1:0]          if_pc_o,
    output logic [DATA_WIDTH-1:0]          id_instr_o,
    output logic [DATA_WIDTH-1:0]          id_pc_o,
    output logic [DATA_WIDTH-1:0]          id_pc_plus4_o,
    output logic                           id_valid_o,
    output logic                           misalign_o
);

    logic [DATA_WIDTH-1:0] pc_s;
    logic [DATA_WIDTH-1:0] pc_plus4_s;
    if_id_t                if_id_d;
    if_id_t                if_id_q;
    if_id_t                bubble_s;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_s),
        .pc_plus4_o    (pc_plus4_s),
        .misalign_o    (misalign_o)
    );

    // Memory depth is smaller than the PC range; upper bits are simply dropped.
    assign imem_addr_o = pc_s[INST_MEM_ADDR_WIDTH+1:2];
    assign if_pc_o     = pc_s;

    assign bubble_s = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};

    // IF/ID next state: redirect and flush both squash; stall holds everything.
    always_comb begin
        if_id_d = if_id_q;
        if (redirect_i) begin
            if_id_d = bubble_s;
        end else if (flush_i) begin
            if_id_d = bubble_s;
        end else if (stall_i) begin
            if_id_d = if_id_q;
        end else begin
            if_id_d = '{instr: imem_data_i, pc: pc_s, pc_plus4: pc_plus4_s, valid: 1'b1};
        end
    end

    // IF/ID pipeline register; reset loads the same bubble as a flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_q <= bubble_s;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign id_instr_o    = if_id_q.instr;
    assign id_pc_o       = if_id_q.pc;
    assign id_pc_plus4_o = if_id_q.pc_plus4;
    assign id_valid_o    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    // Reference architectural state, advanced from the behavioural rules.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic        m_valid;
    logic        m_mis;

    fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .if_pc_o       (if_pc),
        .id_instr_o    (id_instr),
        .id_pc_o       (id_pc),
        .id_pc_plus4_o (id_pc4),
        .id_valid_o    (id_valid),
        .misalign_o    (misalign)
    );

    // Standard program image: word k holds k+1 (256-word memory).
    assign imem_data = {24'd0, imem_addr} + 32'd1;

    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return ((byte_addr / 32'd4) % 32'd256) + 32'd1;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the reference model, sample after the edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic rd, input logic [31:0] t);
        logic [31:0] n_pc, n_instr, n_ipc, n_ipc4;
        logic        n_valid, n_mis;
        rst = r; stall = s; flush = f; redir = rd; rpc = t;
        n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc; n_ipc4 = m_ipc4;
        n_valid = m_valid; n_mis = 1'b0;
        if (r) begin
            n_pc = 32'd0; n_instr = 32'h13; n_ipc = 32'd0; n_ipc4 = 32'd0; n_valid = 1'b0;
        end else if (rd) begin
            n_pc = t - (t % 32'd4);
            n_instr = 32'h13; n_ipc = 32'd0; n_ipc4 = 32'd0; n_valid = 1'b0;
            n_mis = (t % 32'd4) != 32'd0;
        end else if (f) begin
            n_instr = 32'h13; n_ipc = 32'd0; n_ipc4 = 32'd0; n_valid = 1'b0;
            if (!s) n_pc = m_pc + 32'd4;
        end else if (!s) begin
            n_instr = mem_word(m_pc); n_ipc = m_pc; n_ipc4 = m_pc + 32'd4;
            n_valid = 1'b1; n_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc; m_ipc4 = n_ipc4;
        m_valid = n_valid; m_mis = n_mis;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = 32'd0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0042);
        total++; if (if_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", if_pc, 32'd0); end
        total++; if (id_instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=%h", id_instr, 32'h13); end
        total++; if (id_pc !== 32'd0 || id_pc4 !== 32'd0) begin bad++; $display("FAIL reset_idpc got=%h/%h exp=0/0", id_pc, id_pc4); end
        total++; if (id_valid !== 1'b0 || misalign !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b/%b exp=0/0", id_valid, misalign); end
        total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_sequential(input string tag);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            total++; if (id_pc !== 32'(4 * i) || id_instr !== 32'(i + 1) || id_valid !== 1'b1 || id_pc4 !== 32'(4 * i + 4)) begin
                bad++; $display("FAIL %s_%0d got pc=%h instr=%h v=%b p4=%h exp pc=%h instr=%h v=1",
                                tag, i, id_pc, id_instr, id_valid, id_pc4, 4 * i, i + 1);
            end
            total++; if (imem_addr !== 8'(i + 1)) begin bad++; $display("FAIL %s_addr%0d got=%h exp=%h", tag, i, imem_addr, i + 1); end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            total++; if (if_pc !== 32'd8 || id_instr !== 32'd2 || id_pc !== 32'd4 || id_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got pc=%h instr=%h idpc=%h v=%b exp 8/2/4/1", i, if_pc, id_instr, id_pc, id_valid);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (id_instr !== 32'd3 || id_pc !== 32'd8) begin
            bad++; $display("FAIL stall_release got instr=%h idpc=%h exp 3/8", id_instr, id_pc);
        end
    endtask

    task automatic test_redirect();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h14);
        total++; if (if_pc !== 32'h14 || id_valid !== 1'b0 || id_instr !== 32'h13 || misalign !== 1'b0) begin
            bad++; $display("FAIL redir_bubble got pc=%h v=%b instr=%h mis=%b exp 14/0/13/0", if_pc, id_valid, id_instr, misalign);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (id_instr !== 32'd6 || id_pc !== 32'h14 || id_pc4 !== 32'h18 || id_valid !== 1'b1) begin
            bad++; $display("FAIL redir_target got instr=%h pc=%h p4=%h v=%b exp 6/14/18/1", id_instr, id_pc, id_pc4, id_valid);
        end
    endtask

    task automatic test_redirect_priority();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3E);
        total++; if (if_pc !== 32'h3C || misalign !== 1'b1 || id_valid !== 1'b0 || id_instr !== 32'h13) begin
            bad++; $display("FAIL redir_prio got pc=%h mis=%b v=%b instr=%h exp 3c/1/0/13", if_pc, misalign, id_valid, id_instr);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (id_instr !== 32'h10 || misalign !== 1'b0 || id_pc !== 32'h3C) begin
            bad++; $display("FAIL redir_prio_next got instr=%h mis=%b idpc=%h exp 10/0/3c", id_instr, misalign, id_pc);
        end
    endtask

    task automatic test_flush_stall();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        total++; if (id_valid !== 1'b0 || id_instr !== 32'h13 || id_pc !== 32'd0 || if_pc !== 32'hC) begin
            bad++; $display("FAIL flush_stall got v=%b instr=%h idpc=%h pc=%h exp 0/13/0/c", id_valid, id_instr, id_pc, if_pc);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (id_instr !== 32'd4 || id_valid !== 1'b1) begin
            bad++; $display("FAIL flush_resume got instr=%h v=%b exp 4/1", id_instr, id_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        total++; if (if_pc !== 32'h14 || id_valid !== 1'b0) begin
            bad++; $display("FAIL flush_advance got pc=%h v=%b exp 14/0", if_pc, id_valid);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1D);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (if_pc !== 32'h20 || id_valid !== 1'b1 || misalign !== 1'b0) begin
            bad++; $display("FAIL midrst_setup got pc=%h v=%b mis=%b exp 20/1/0", if_pc, id_valid, misalign);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h3F);
        total++; if (if_pc !== 32'd0 || id_valid !== 1'b0 || misalign !== 1'b0 || id_instr !== 32'h13) begin
            bad++; $display("FAIL midrst got pc=%h v=%b mis=%b instr=%h exp 0/0/0/13", if_pc, id_valid, misalign, id_instr);
        end
        test_sequential("replay");
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        total++; if (imem_addr !== 8'hFF) begin bad++; $display("FAIL wrap_addr got=%h exp=ff", imem_addr); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        total++; if (if_pc !== 32'd0 || id_instr !== 32'h100 || id_pc4 !== 32'd0 || id_pc !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap got pc=%h instr=%h p4=%h idpc=%h exp 0/100/0/fffffffc", if_pc, id_instr, id_pc4, id_pc);
        end
    endtask

    task automatic test_random();
        logic r, s, f, rd;
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2047)) : $urandom;
            step(r, s, f, rd, t);
            total++;
            if (if_pc !== m_pc || id_instr !== m_instr || id_pc !== m_ipc || id_pc4 !== m_ipc4 ||
                id_valid !== m_valid || misalign !== m_mis || imem_addr !== m_pc[9:2]) begin
                bad++;
                $display("FAIL rand_%0d got pc=%h in=%h ip=%h p4=%h v=%b m=%b a=%h exp pc=%h in=%h ip=%h p4=%h v=%b m=%b",
                         i, if_pc, id_instr, id_pc, id_pc4, id_valid, misalign, imem_addr,
                         m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_mis);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = 32'd0;
        m_pc = 32'd0; m_instr = 32'h13; m_ipc = 32'd0; m_ipc4 = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0;
        test_reset();
        test_sequential("seq");
        test_stall();
        test_redirect();
        test_redirect_priority();
        test_flush_stall();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage controller. Owns the program counter, drives the word address into the existing combinational instruction_memory, and registers the fetched word into the IF/ID pipeline register.
- Handles hazard-unit stalls, EX-stage branch/jump redirects and external flushes.
- Supplies the decode stage with instruction, PC, PC+4 and a valid bit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID on flush.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  hold PC and IF/ID contents
- flush_i  in  1  replace the IF/ID entry with a bubble
- redirect_i  in  1  taken branch/jump from EX
- redirect_pc_i  in  DATA_WIDTH  redirect target byte address
- imem_addr_o  out  INST_MEM_ADDR_WIDTH  word address to instruction_memory (rd_addr_i)
- imem_data_i  in  DATA_WIDTH  combinational read data from instruction_memory (rd_data_o)
- if_pc_o  out  DATA_WIDTH  current PC
- id_instr_o  out  DATA_WIDTH  IF/ID instruction
- id_pc_o  out  DATA_WIDTH  IF/ID PC
- id_pc_plus4_o  out  DATA_WIDTH  IF/ID PC+4
- id_valid_o  out  1  IF/ID holds a real instruction
- misalign_o  out  1  one-cycle pulse: redirect target had pc[1:0]!=0

Behaviour:
- Address generation:
  - imem_addr_o = pc[INST_MEM_ADDR_WIDTH+1:2], combinational.
  - PCs beyond memory depth wrap by truncation. No error is raised.
- Reset (rst_i=1 at an edge), overriding all other inputs:
  - pc=RESET_PC
  - id_instr_o=NOP_INSTR, id_pc_o=0, id_pc_plus4_o=0
  - id_valid_o=0, misalign_o=0
- Reset mid-operation: state is discarded in one edge, with no partial updates.
- Per-edge priority: rst_i > redirect_i > flush_i > stall_i > normal.
- Normal operation:
  - pc <= pc+4 (32-bit, wraps at 2^32).
  - IF/ID <= {imem_data_i, pc, pc+4}, valid=1.
- stall_i (no redirect, no flush): pc and all IF/ID outputs hold, including id_valid_o.
- flush_i (no redirect):
  - IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc/pc_plus4 fields = 0.
  - pc advances by 4 unless stall_i is set, in which case pc holds.
- redirect_i:
  - pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}.
  - IF/ID <= bubble, which squashes the wrong-path word.
  - Overrides stall_i and flush_i.
- misalign_o:
  - Registered. Asserted for exactly one cycle after a redirect edge with redirect_pc_i[1:0]!=0.
  - Otherwise 0.
- Latency:
  - The word at PC X appears on id_instr_o one edge after pc==X with no stall.
  - After a redirect, the first valid target instruction appears on the second edge after redirect_i is sampled.
- Fetch is always single-cycle because the memory is combinational. No request/ack handshake exists.

Decomposition:
- Package defines: DATA_WIDTH and INST_MEM_ADDR_WIDTH (existing), plus new constants NOP_INSTR and RESET_PC_DEFAULT.
- Add a typedef if_id_t struct {instr, pc, pc_plus4, valid} for reuse by the decode stage.
- One natural sub-module: program_counter, which covers the PC register, next-PC mux, alignment forcing and misalign flag.
- The IF/ID register stays in fetch_unit.
- instruction_memory is instantiated at the top level alongside, not inside, fetch_unit.

Test Plan:
All cases use the standard program.mem, where word k holds k+1.
1. Release reset, run 4 cycles:
   - id_pc_o = 0,4,8,0xC.
   - id_instr_o = 1,2,3,4.
   - id_valid_o=1 from the first edge; imem_addr_o = 0..4.
2. stall_i=1 for 2 cycles while pc=8:
   - pc holds 8; id_instr_o holds 2, id_pc_o holds 4.
   - After release: id_instr_o=3, id_pc_o=8.
3. redirect_i=1, redirect_pc_i=0x14:
   - Next cycle: pc=0x14, id_valid_o=0, id_instr_o=0x13.
   - Following edge: id_instr_o=6, id_pc_o=0x14, id_pc_plus4_o=0x18.
4. redirect_i (0x3E) with stall_i=1 and flush_i=1 in the same cycle:
   - pc=0x3C; misalign_o=1 for one cycle; bubble in IF/ID.
   - Next edge: id_instr_o=0x10.
5. flush_i with stall_i at pc=0xC:
   - IF/ID becomes bubble (valid=0, instr 0x13); pc holds 0xC.
   - Next normal edge: id_instr_o=4.
6. rst_i asserted mid-run at pc=0x20:
   - Next edge: pc=0, id_valid_o=0, misalign_o=0.
   - Resumed fetch replays scenario 1's values.
